// File: rtl/dmem_responder_if.sv
// Request/response bundle between a data-side initiator (the core) and the
// memory responder. The master drives requests and accepts responses.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs a byte-enabled word access on internal storage
// and returns the result over a valid/ready response channel.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstd,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 1;

  // S_EXEC is the single access edge; it follows the wait states so that the
  // response appears WAIT_CYCLES+1 cycles after acceptance for every setting.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;

  logic [31:0]       mem_r [DEPTH_WORDS];

  logic [31:0]       offset_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              commit_s;

  // Decode the latched address into a word index and range verdict.
  always_comb begin
    offset_s   = addr_r - BASE_ADDR;
    in_range_s = (addr_r >= BASE_ADDR) && ((offset_s >> 2) < 32'(DEPTH_WORDS));
    idx_s      = offset_s[IDX_W+1:2];
    if ((state_r == S_EXEC) && we_r && in_range_s && rstd) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Byte-lane store into storage; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_r[b]) begin
          mem_r[idx_s][8*b +: 8] <= wdata_r[8*b +: 8];
        end
      end
    end
  end

  // Transaction sequencing with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_r      <= S_IDLE;
      cnt_r        <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      wstrb_r      <= 4'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            wstrb_r <= bus.req_wstrb;
            if (WAIT_CYCLES == 32'd0) begin
              state_r <= S_EXEC;
            end else begin
              cnt_r   <= 4'(WAIT_CYCLES) - 4'd1;
              state_r <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_EXEC;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_EXEC: begin
          state_r      <= S_RESP;
          resp_valid_r <= 1'b1;
          if (!in_range_s) begin
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'd0;
          end else if (we_r) begin
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
          end else begin
            resp_err_r   <= 1'b0;
            resp_rdata_r <= mem_r[idx_s];
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_r      <= S_IDLE;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_r == S_IDLE) && rstd;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states and one with
// none, driven by directed and random transactions against a word-map model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rstd;
  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_dut_a (
    .clk(clk), .rstd(rstd), .bus(bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_dut_b (
    .clk(clk), .rstd(rstd), .bus(bus_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;                 // 0: two-wait instance, 1: zero-wait instance
  logic [31:0] model [int];    // expected word contents, keyed per instance

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic o_ready();
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction
  function automatic logic o_valid();
    return (sel == 0) ? bus_a.resp_valid : bus_b.resp_valid;
  endfunction
  function automatic logic [31:0] o_rdata();
    return (sel == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
  endfunction
  function automatic logic o_err();
    return (sel == 0) ? bus_a.resp_err : bus_b.resp_err;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
  endfunction
  function automatic int key(input logic [31:0] a);
    return sel * 8192 + int'((a - BASE) >> 2);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d; bus_a.req_wstrb = s;
    bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d; bus_b.req_wstrb = s;
    bus_a.req_valid = v & (sel == 0);
    bus_b.req_valid = v & (sel == 1);
  endtask

  task automatic set_rr(input logic r);
    bus_a.resp_ready = r & (sel == 0);
    bus_b.resp_ready = r & (sel == 1);
  endtask

  // One complete transaction with latency, hold and release checks.
  task automatic txn(input string tag, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int bp,
                     output logic [31:0] got);
    logic [31:0] exp_d;
    logic [31:0] w;
    logic        exp_e;
    bit          known;
    int          lat;
    exp_e = !in_range(a);
    exp_d = 32'd0;
    known = 1'b1;
    if (!exp_e) begin
      if (we) begin
        if (model.exists(key(a)) || s == 4'hF) begin
          w = model.exists(key(a)) ? model[key(a)] : 32'd0;
          for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
          model[key(a)] = w;
        end
      end else if (model.exists(key(a))) begin
        exp_d = model[key(a)];
      end else begin
        known = 1'b0;
      end
    end
    chk({tag, ".req_ready_idle"}, {31'd0, o_ready()}, 32'd1);
    set_rr(1'b0);
    set_req(1'b1, we, a, d, s);
    step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 0;
    while (!o_valid() && lat < 40) begin
      chk({tag, ".req_ready_busy"}, {31'd0, o_ready()}, 32'd0);
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, (sel == 0) ? 32'd3 : 32'd1);
    got = o_rdata();
    if (known) chk({tag, ".rdata"}, o_rdata(), exp_d);
    chk({tag, ".err"}, {31'd0, o_err()}, {31'd0, exp_e});
    for (int i = 0; i < bp; i++) begin
      step();
      chk({tag, ".hold_valid"}, {31'd0, o_valid()}, 32'd1);
      if (known) chk({tag, ".hold_rdata"}, o_rdata(), exp_d);
      chk({tag, ".hold_err"}, {31'd0, o_err()}, {31'd0, exp_e});
      chk({tag, ".hold_req_ready"}, {31'd0, o_ready()}, 32'd0);
    end
    set_rr(1'b1);
    step();
    set_rr(1'b0);
    chk({tag, ".resp_drop"}, {31'd0, o_valid()}, 32'd0);
    chk({tag, ".req_ready_after"}, {31'd0, o_ready()}, 32'd1);
  endtask

  // Accept a store, then reset on the following edge; nothing may commit.
  task automatic abort_store(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".req_ready_idle"}, {31'd0, o_ready()}, 32'd1);
    set_req(1'b1, 1'b1, a, d, 4'hF);
    step();
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rstd = 1'b0;
    step();
    chk({tag, ".rst_valid"}, {31'd0, o_valid()}, 32'd0);
    chk({tag, ".rst_ready"}, {31'd0, o_ready()}, 32'd0);
    rstd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk({tag, ".no_resp"}, {31'd0, o_valid()}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        we;
    int          r;

    rstd = 1'b0;
    sel  = 0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    bus_a.resp_ready = 1'b0;
    bus_b.resp_ready = 1'b0;

    // Reset held for three cycles on both instances.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.a_ready", {31'd0, bus_a.req_ready}, 32'd0);
      chk("rst.a_valid", {31'd0, bus_a.resp_valid}, 32'd0);
      chk("rst.a_rdata", bus_a.resp_rdata, 32'd0);
      chk("rst.b_ready", {31'd0, bus_b.req_ready}, 32'd0);
      chk("rst.b_valid", {31'd0, bus_b.resp_valid}, 32'd0);
      chk("rst.b_rdata", bus_b.resp_rdata, 32'd0);
    end
    rstd = 1'b1;
    #1;
    chk("rel.a_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("rel.b_ready", {31'd0, bus_b.req_ready}, 32'd1);

    // Store then load on the two-wait instance.
    sel = 0;
    txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    chk("ld10.const", got, 32'hDEAD_BEEF);

    // Byte-lane merge.
    txn("st20", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, got);
    txn("st20m", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1, got);
    txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    chk("ld20.const", got, 32'h11BB_33DD);

    // Empty strobe completes without changing the word.
    txn("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, got);
    txn("ld20z", 1'b0, 32'h22, 32'h0, 4'h0, 0, got);
    chk("ld20z.const", got, 32'h11BB_33DD);

    // Out of range just past the last word; last word must be untouched.
    txn("st3ffc", 1'b1, 32'h3FFC, 32'h5A5A_A5A5, 4'hF, 0, got);
    txn("st4000", 1'b1, 32'h4000, 32'h0BAD_0BAD, 4'hF, 0, got);
    txn("ld4000", 1'b0, 32'h4000, 32'h0, 4'h0, 0, got);
    txn("ld3ffc", 1'b0, 32'h3FFC, 32'h0, 4'h0, 0, got);
    chk("ld3ffc.const", got, 32'h5A5A_A5A5);

    // Response backpressure for five cycles.
    txn("bp10", 1'b0, 32'h10, 32'h0, 4'h0, 5, got);
    chk("bp10.const", got, 32'hDEAD_BEEF);

    // Reset mid-wait abandons the store.
    txn("st30", 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 0, got);
    abort_store("abort_a", 32'h30, 32'h1234_5678);
    txn("ld30", 1'b0, 32'h30, 32'h0, 4'h0, 0, got);
    chk("ld30.const", got, 32'hCAFE_F00D);

    // Reset coinciding with a request: nothing accepted.
    rstd = 1'b0;
    set_req(1'b1, 1'b1, 32'h10, 32'h0000_0000, 4'hF);
    step();
    chk("rstreq.ready", {31'd0, o_ready()}, 32'd0);
    set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rstd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstreq.no_resp", {31'd0, o_valid()}, 32'd0);
    end
    txn("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    chk("ld10b.const", got, 32'hDEAD_BEEF);

    // Zero-wait instance: latency of one cycle and reset abort.
    sel = 1;
    txn("b.st30", 1'b1, 32'h30, 32'h0F0F_0F0F, 4'hF, 0, got);
    txn("b.ld30", 1'b0, 32'h30, 32'h0, 4'h0, 2, got);
    chk("b.ld30.const", got, 32'h0F0F_0F0F);
    abort_store("abort_b", 32'h30, 32'h1234_5678);
    txn("b.ld30r", 1'b0, 32'h30, 32'h0, 4'h0, 0, got);
    chk("b.ld30r.const", got, 32'h0F0F_0F0F);

    // Random traffic over a small word pool on both instances.
    for (int k = 0; k < 2; k++) begin
      sel = k;
      for (int i = 0; i < 16; i++) begin
        txn("rnd.init", 1'b1, 32'h100 + 32'(i * 4), $urandom, 4'hF, 0, got);
      end
    end
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 1);
      r   = $urandom_range(0, 9);
      we  = $urandom_range(0, 1) == 1;
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      if (r == 0) begin
        a = 32'h4000 + (32'($urandom_range(0, 4000)) << 2);
      end else if (r == 1) begin
        a = 32'hFFFF_FFFC;
      end else begin
        a = 32'h100 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      end
      txn("rnd", we, a, d, s, $urandom_range(0, 3), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
